jtag_ahbl_master: RTL

AHB-Lite single-transfer bus master driven by the JTAG debug controller. It accepts decoded debug commands (AHBL ADDRESS, AHBL WRITE, AHBL READ) on a valid/ready command port and sequences the matching AHB-Lite address and data phases, including wait states and error responses. It returns one response per command, holds the current debug address, and optionally post-increments it. It sits between the TAP instruction/data-register logic, already synchronized into HCLK, and the system AHB-Lite fabric.

---
 rtl/jtag_ahbl_master.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/jtag_ahbl_master.sv
// jtag_ahbl_master: AHB-Lite single-transfer master for the JTAG debug path.
// Takes SET_ADDR / WRITE / READ commands, runs one NONSEQ word transfer per
// bus command and returns exactly one response pulse per command.
module jtag_ahbl_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter bit AUTO_INC   = 1'b1
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic [7:0]            rsp_waits,
   output logic [ADDR_WIDTH-1:0] HADDR,
   output logic [1:0]            HTRANS,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [2:0]            HBURST,
   output logic [3:0]            HPROT,
   output logic                  HMASTLOCK,
   output logic [DATA_WIDTH-1:0] HWDATA,
   input  logic [DATA_WIDTH-1:0] HRDATA,
   input  logic                  HREADY,
   input  logic                  HRESP
);

   // state  | meaning
   // IDLE   | waiting for a command, cmd_ready high
   // ADDR   | NONSEQ address phase, held while HREADY low
   // DATA   | data phase, counting wait states and collecting errors
   // RESP   | one-cycle response pulse, back to IDLE next cycle
   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_e;

   localparam logic [1:0] OP_SET_ADDR = 2'b00;
   localparam logic [1:0] OP_WRITE    = 2'b01;
   localparam logic [1:0] OP_READ     = 2'b10;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] haddr_q;
   logic [1:0]            htrans_q;
   logic                  write_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  err_flag_q;
   logic [7:0]            wait_cnt_q;
   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_data_q;
   logic                  rsp_err_q;
   logic [7:0]            rsp_waits_q;

   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic                  done_err;

   assign cmd_addr = cmd_data[ADDR_WIDTH-1:0];
   // An error seen on an earlier stalled cycle sticks even if the final
   // cycle's HRESP were to drop.
   assign done_err = HRESP | err_flag_q;

   // Command sequencing, bus phases and registered response outputs.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         haddr_q     <= '0;
         htrans_q    <= HTRANS_IDLE;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         err_flag_q  <= 1'b0;
         wait_cnt_q  <= 8'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         rsp_waits_q <= 8'd0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  case (cmd_op)
                     OP_SET_ADDR: begin
                        addr_q      <= cmd_addr;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= DATA_WIDTH'(cmd_addr);
                        rsp_err_q   <= 1'b0;
                        rsp_waits_q <= 8'd0;
                        state_q     <= S_RESP;
                     end
                     OP_WRITE, OP_READ: begin
                        if (addr_q[1:0] != 2'b00) begin
                           rsp_valid_q <= 1'b1;
                           rsp_data_q  <= '0;
                           rsp_err_q   <= 1'b1;
                           rsp_waits_q <= 8'd0;
                           state_q     <= S_RESP;
                        end else begin
                           write_q  <= (cmd_op == OP_WRITE);
                           if (cmd_op == OP_WRITE) begin
                              wdata_q <= cmd_data;
                           end
                           haddr_q  <= addr_q;
                           htrans_q <= HTRANS_NONSEQ;
                           state_q  <= S_ADDR;
                        end
                     end
                     default: begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_waits_q <= 8'd0;
                        state_q     <= S_RESP;
                     end
                  endcase
               end
            end
            S_ADDR: begin
               if (HREADY) begin
                  htrans_q   <= HTRANS_IDLE;
                  err_flag_q <= 1'b0;
                  wait_cnt_q <= 8'd0;
                  state_q    <= S_DATA;
               end
            end
            S_DATA: begin
               if (!HREADY) begin
                  if (wait_cnt_q != 8'hFF) begin
                     wait_cnt_q <= wait_cnt_q + 8'd1;
                  end
                  if (HRESP) begin
                     err_flag_q <= 1'b1;
                  end
               end else begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= done_err;
                  rsp_data_q  <= (!write_q && !done_err) ? HRDATA : '0;
                  rsp_waits_q <= wait_cnt_q;
                  if (AUTO_INC && !done_err) begin
                     addr_q <= addr_q + ADDR_WIDTH'(4);
                  end
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_waits = rsp_waits_q;
   assign HADDR     = haddr_q;
   assign HTRANS    = htrans_q;
   assign HWRITE    = write_q;
   assign HWDATA    = wdata_q;
   assign HSIZE     = 3'b010;
   assign HBURST    = 3'b000;
   assign HPROT     = 4'b0011;
   assign HMASTLOCK = 1'b0;

endmodule
